// File: rtl/sign_narrower_16in_8out.sv
`default_nettype none
// ============================================================================
// Module   : sign_narrower_16in_8out
// Function : Serialises 16-bit words onto an 8-bit bus, sending sign-extendable
//            words as a single tagged short byte and others as high/low bytes.
// Revision : 1.0 - initial release
// ============================================================================
module sign_narrower_16in_8out #(
    parameter int ENABLE_NARROW = 1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_short,
    output logic                   byte_last,
    output logic [COUNT_WIDTH-1:0] short_count
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [15:0]              r_hold;
    logic [COUNT_WIDTH-1:0]   r_short_count;
    logic                     w_accept;
    logic                     w_is_short;
    logic                     w_short_done;

    // word_ready is masked by rst so nothing is accepted during reset
    assign word_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept     = word_valid && word_ready;
    assign w_is_short   = (ENABLE_NARROW != 0) && (word_in[15:8] == {8{word_in[7]}});
    assign w_short_done = (r_state == ST_SHORT) && byte_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_state_nxt = w_is_short ? ST_SHORT : ST_HIGH;
            ST_SHORT: if (byte_ready) w_state_nxt = ST_IDLE;
            ST_HIGH:  if (byte_ready) w_state_nxt = ST_LOW;
            ST_LOW:   if (byte_ready) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hold        <= 16'h0000;
            r_short_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_hold <= word_in;
            end
            if (w_short_done && (r_short_count != c_count_max)) begin
                r_short_count <= r_short_count + 1'b1;
            end
        end
    end

    // Outputs decode purely from state and hold, never from the handshakes
    always_comb begin
        byte_out   = 8'h00;
        byte_valid = 1'b0;
        byte_short = 1'b0;
        byte_last  = 1'b0;
        case (r_state)
            ST_SHORT: begin
                byte_out   = r_hold[7:0];
                byte_valid = 1'b1;
                byte_short = 1'b1;
                byte_last  = 1'b1;
            end
            ST_HIGH: begin
                byte_out   = r_hold[15:8];
                byte_valid = 1'b1;
            end
            ST_LOW: begin
                byte_out   = r_hold[7:0];
                byte_valid = 1'b1;
                byte_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign short_count = r_short_count;

endmodule
`default_nettype wire

// File: tb/tb_sign_narrower_16in_8out.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_narrower_16in_8out
// Function : Directed self-checking bench for sign_narrower_16in_8out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_narrower_16in_8out;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0: default parameters
    logic [15:0] word_in0 = '0;
    logic        word_valid0 = 1'b0, byte_ready0 = 1'b0;
    logic        word_ready0, byte_valid0, byte_short0, byte_last0;
    logic [7:0]  byte_out0;
    logic [15:0] short_count0;

    // Instance 1: narrowing disabled
    logic [15:0] word_in1 = '0;
    logic        word_valid1 = 1'b0, byte_ready1 = 1'b0;
    logic        word_ready1, byte_valid1, byte_short1, byte_last1;
    logic [7:0]  byte_out1;
    logic [15:0] short_count1;

    // Instance 2: 4-bit counter for saturation
    logic [15:0] word_in2 = '0;
    logic        word_valid2 = 1'b0, byte_ready2 = 1'b0;
    logic        word_ready2, byte_valid2, byte_short2, byte_last2;
    logic [7:0]  byte_out2;
    logic [3:0]  short_count2;

    sign_narrower_16in_8out u_dut0 (
        .clk(clk), .rst(rst), .word_in(word_in0), .word_valid(word_valid0),
        .word_ready(word_ready0), .byte_out(byte_out0), .byte_valid(byte_valid0),
        .byte_ready(byte_ready0), .byte_short(byte_short0), .byte_last(byte_last0),
        .short_count(short_count0)
    );

    sign_narrower_16in_8out #(.ENABLE_NARROW(0)) u_dut1 (
        .clk(clk), .rst(rst), .word_in(word_in1), .word_valid(word_valid1),
        .word_ready(word_ready1), .byte_out(byte_out1), .byte_valid(byte_valid1),
        .byte_ready(byte_ready1), .byte_short(byte_short1), .byte_last(byte_last1),
        .short_count(short_count1)
    );

    sign_narrower_16in_8out #(.COUNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .word_in(word_in2), .word_valid(word_valid2),
        .word_ready(word_ready2), .byte_out(byte_out2), .byte_valid(byte_valid2),
        .byte_ready(byte_ready2), .byte_short(byte_short2), .byte_last(byte_last2),
        .short_count(short_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [15:0] w);
        check("dut0 ready before accept", 32'(word_ready0), 32'd1);
        word_in0    = w;
        word_valid0 = 1'b1;
        tick();
        word_valid0 = 1'b0;
    endtask

    task automatic take0(input string tag, input logic [7:0] b, input logic s, input logic l);
        check({tag, " valid"}, 32'(byte_valid0), 32'd1);
        check({tag, " byte"},  32'(byte_out0),   32'(b));
        check({tag, " short"}, 32'(byte_short0), 32'(s));
        check({tag, " last"},  32'(byte_last0),  32'(l));
        byte_ready0 = 1'b1;
        tick();
        byte_ready0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] w);
        check("dut1 ready before accept", 32'(word_ready1), 32'd1);
        word_in1    = w;
        word_valid1 = 1'b1;
        tick();
        word_valid1 = 1'b0;
    endtask

    task automatic take1(input string tag, input logic [7:0] b, input logic l);
        check({tag, " valid"}, 32'(byte_valid1), 32'd1);
        check({tag, " byte"},  32'(byte_out1),   32'(b));
        check({tag, " short"}, 32'(byte_short1), 32'd0);
        check({tag, " last"},  32'(byte_last1),  32'(l));
        byte_ready1 = 1'b1;
        tick();
        byte_ready1 = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        check("ready during rst", 32'(word_ready0), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("reset ready",  32'(word_ready0),   32'd1);
        check("reset byte",   32'(byte_out0),     32'h00);
        check("reset valid",  32'(byte_valid0),   32'd0);
        check("reset short",  32'(byte_short0),   32'd0);
        check("reset last",   32'(byte_last0),    32'd0);
        check("reset count",  32'(short_count0),  32'd0);

        // byte_ready in IDLE is ignored
        byte_ready0 = 1'b1;
        tick();
        byte_ready0 = 1'b0;
        check("idle ready ignored count", 32'(short_count0), 32'd0);
        check("idle ready ignored valid", 32'(byte_valid0),  32'd0);

        // Short positive / negative
        send0(16'h007F);
        take0("0x007F", 8'h7F, 1'b1, 1'b1);
        check("count after 0x007F", 32'(short_count0), 32'd1);
        check("idle after short",   32'(byte_valid0),  32'd0);
        send0(16'hFF80);
        take0("0xFF80", 8'h80, 1'b1, 1'b1);
        check("count after 0xFF80", 32'(short_count0), 32'd2);

        // Non-extendable words
        send0(16'h0080);
        take0("0x0080 hi", 8'h00, 1'b0, 1'b0);
        take0("0x0080 lo", 8'h80, 1'b0, 1'b1);
        send0(16'hFF7F);
        take0("0xFF7F hi", 8'hFF, 1'b0, 1'b0);
        take0("0xFF7F lo", 8'h7F, 1'b0, 1'b1);
        check("count after long words", 32'(short_count0), 32'd2);

        // Backpressure with a competing word held valid
        send0(16'h1234);
        word_in0    = 16'h0011;
        word_valid0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall byte",  32'(byte_out0),   32'h12);
            check("stall valid", 32'(byte_valid0), 32'd1);
            check("stall ready", 32'(word_ready0), 32'd0);
            tick();
        end
        take0("0x1234 hi", 8'h12, 1'b0, 1'b0);
        take0("0x1234 lo", 8'h34, 1'b0, 1'b1);
        check("ready after long", 32'(word_ready0), 32'd1);
        check("valid after long", 32'(byte_valid0), 32'd0);
        tick();
        word_valid0 = 1'b0;
        take0("queued 0x0011", 8'h11, 1'b1, 1'b1);
        check("count after queued", 32'(short_count0), 32'd3);

        // ENABLE_NARROW=0
        send1(16'h0005);
        take1("nonarrow 0x0005 hi", 8'h00, 1'b0);
        take1("nonarrow 0x0005 lo", 8'h05, 1'b1);
        send1(16'hFFFF);
        take1("nonarrow 0xFFFF hi", 8'hFF, 1'b0);
        take1("nonarrow 0xFFFF lo", 8'hFF, 1'b1);
        check("nonarrow count", 32'(short_count1), 32'd0);

        // Saturation of a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            check("sat ready", 32'(word_ready2), 32'd1);
            word_in2    = 16'hFFFF;
            word_valid2 = 1'b1;
            tick();
            word_valid2 = 1'b0;
            check("sat short", 32'(byte_short2), 32'd1);
            check("sat byte",  32'(byte_out2),   32'hFF);
            byte_ready2 = 1'b1;
            tick();
            byte_ready2 = 1'b0;
            if (i == 13) check("sat count 14", 32'(short_count2), 32'd14);
        end
        check("sat count final", 32'(short_count2), 32'hF);

        // Reset mid-word
        send0(16'hABCD);
        take0("0xABCD hi", 8'hAB, 1'b0, 1'b0);
        check("before rst in low", 32'(byte_out0), 32'hCD);
        rst = 1'b1;
        tick();
        check("rst mid valid", 32'(byte_valid0),  32'd0);
        check("rst mid ready", 32'(word_ready0),  32'd0);
        check("rst mid count", 32'(short_count0), 32'd0);
        rst = 1'b0;
        #1;
        check("post rst ready", 32'(word_ready0), 32'd1);
        check("post rst byte",  32'(byte_out0),   32'h00);
        byte_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no 0xCD emitted", 32'(byte_valid0), 32'd0);
        end
        byte_ready0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sign_narrower_16in_8out.md
# sign_narrower_16in_8out

Byte-stream encoder that converts 16-bit processor words onto an 8-bit bus. Its output is the input format expected by the 8-to-16 sign extender. A word whose upper byte is pure sign extension of its lower byte goes out as one tagged short byte; any other word goes out as two bytes, high byte first. The block sits between the 16-bit datapath and byte-wide memory/IO paths, with valid/ready handshakes on both sides.

## Interface
Parameters:
- ENABLE_NARROW, default 1: when 1, sign-extendable words are sent as one byte. When 0, every word is sent as two bytes.
- COUNT_WIDTH, default 16: width of the short-word counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- word_in  input  16  word to encode; sampled only on an accept.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can accept a word this cycle.
- byte_out  output  8  output byte.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  consumer takes byte_out this cycle.
- byte_short  output  1  the current byte is a complete short word; the receiver sign-extends it.
- byte_last  output  1  the current byte is the final byte of its word.
- short_count  output  COUNT_WIDTH  number of short words sent; saturates at its maximum value.

## Operation
- Accept: occurs when word_valid && word_ready. word_in is latched into a 16-bit hold register.
- Short test: short = ENABLE_NARROW && (hold[15:8] == {8{hold[7]}}).
  - Short examples: 0x0000–0x007F and 0xFF80–0xFFFF.
  - The test is evaluated on word_in at accept time; the result selects the next state.
- FSM states: IDLE, SHORT, HIGH, LOW.
  - IDLE: word_ready=1, byte_valid=0. On accept, go to SHORT if short, otherwise to HIGH.
  - SHORT: byte_out=hold[7:0], byte_valid=1, byte_short=1, byte_last=1. On byte_ready, go to IDLE and increment short_count.
  - HIGH: byte_out=hold[15:8], byte_valid=1, byte_short=0, byte_last=0. On byte_ready, go to LOW.
  - LOW: byte_out=hold[7:0], byte_valid=1, byte_short=0, byte_last=1. On byte_ready, go to IDLE.
- word_ready is 1 only in IDLE. No word is accepted while a byte is pending.
- Output stability: while byte_valid=1 and byte_ready=0, byte_out, byte_short and byte_last hold their values, and the hold register does not change.
- byte_short and byte_last are 0 whenever byte_valid=0. byte_out is 0x00 in IDLE.
- short_count:
  - Increments only on a completed SHORT handshake.
  - At all-ones it stays at all-ones.
  - Never decrements.
- Reset: in any state, rst=1 at a clock edge sets the following:
  - state=IDLE and hold=0x0000.
  - short_count=0.
  - Any in-flight word is discarded, even if only its high byte was sent.
- Reset values of outputs: word_ready=1 (rst is low and state=IDLE), byte_out=0x00, byte_valid=0, byte_short=0, byte_last=0, short_count=0.
  - While rst=1, word_ready=0 and no accept occurs.
- Simultaneous events: byte_ready is ignored in IDLE. word_valid is ignored outside IDLE. word_valid and byte_ready both high in SHORT or LOW completes the byte only; the new word is accepted in the next cycle, in IDLE.

## Timing
- Latency: byte_valid rises in the cycle after the accept edge.
- Throughput:
  - Short word: 2 cycles minimum (accept, then send).
  - Long word: 3 cycles minimum (accept, high byte, low byte).
- Backpressure adds one cycle per cycle that byte_ready stays low; there is no limit on stall length.
- All outputs come directly from registers or decode of state/hold. There is no combinational path from byte_ready or word_valid to any output.

## Test plan
- Short positive: word 0x007F. Expect one byte 0x7F with short=1, last=1; short_count becomes 1.
- Short negative: word 0xFF80. Expect one byte 0x80 with short=1, last=1.
- Non-extendable: word 0x0080. Expect 0x00 (short=0, last=0), then 0x80 (short=0, last=1).
- Non-extendable: word 0xFF7F. Expect 0xFF, then 0x7F; short_count unchanged.
- Backpressure: word 0x1234 with byte_ready held low for 5 cycles. byte_out holds 0x12 throughout and word_ready stays 0. Release byte_ready: 0x34 follows, then word_ready returns to 1.
- ENABLE_NARROW=0: word 0x0005. Expect two bytes 0x00 and 0x05, both short=0.
- Reset mid-word: word 0xABCD; assert rst after the 0xAB handshake. Expect state IDLE, byte_valid=0, short_count=0, and 0xCD is never emitted.
- Saturation: with COUNT_WIDTH=4, send 17 short words. short_count stops at 0xF.
